// File: rtl/clk_div_pkg.sv
// ----------------------------------------------------------------------------
// clk_div_pkg
//   Shared definitions for the prog_clk_div programmable clock divider:
//   default counter width, default reset divisor, per-channel state type and
//   the channel-index width helper used by the interface and the top level.
// ----------------------------------------------------------------------------
package clk_div_pkg;

    localparam int CNT_W_DFLT   = 26;
    localparam int DEF_DIV_DFLT = 5000;

    typedef enum logic [1:0] {
        OFF  = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } ch_state_t;

    // Channel select width; a single-channel build still gets a 1-bit select.
    function automatic int ch_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/prog_clk_div_if.sv
// ----------------------------------------------------------------------------
// prog_clk_div_if
//   Bundles the run enables, the divisor-write handshake, the phase-align
//   pulse and the divided outputs of prog_clk_div.
//   Signals:
//     chEn     [NUM_CH]  per-channel run enable
//     cfgValid           divisor write request
//     cfgCh    [CH_W]    target channel of the write
//     cfgDiv   [CNT_W]   new divisor (half period = cfgDiv+1 cycles)
//     cfgReady           write accepted when cfgValid && cfgReady
//     syncIn             phase-align pulse
//     clkOut   [NUM_CH]  divided clocks, 50% duty
//     tickOut  [NUM_CH]  1-cycle pulse on each clkOut rise
//   Modports: master (drives requests), slave (the divider).
// ----------------------------------------------------------------------------
interface prog_clk_div_if #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = clk_div_pkg::CNT_W_DFLT
);
    localparam int CH_W = clk_div_pkg::ch_idx_w(NUM_CH);

    logic [NUM_CH-1:0] chEn;
    logic              cfgValid;
    logic [CH_W-1:0]   cfgCh;
    logic [CNT_W-1:0]  cfgDiv;
    logic              cfgReady;
    logic              syncIn;
    logic [NUM_CH-1:0] clkOut;
    logic [NUM_CH-1:0] tickOut;

    modport master (
        output chEn, cfgValid, cfgCh, cfgDiv, syncIn,
        input  cfgReady, clkOut, tickOut
    );

    modport slave (
        input  chEn, cfgValid, cfgCh, cfgDiv, syncIn,
        output cfgReady, clkOut, tickOut
    );

endinterface

// File: rtl/clk_div_chan.sv
// ----------------------------------------------------------------------------
// clk_div_chan
//   One divider channel: counter, active/pending divisor, OFF/RUN/STOP FSM and
//   registered clock/tick outputs. Optional feature macro: CLKDIV_SYNC_EN
//   (phase-align on i_sync while in RUN); without it i_sync is ignored.
//   Ports:
//     clkIn, rstIn  clock, synchronous active-high reset
//     i_en          run enable
//     i_we          accepted divisor write for this channel
//     i_wdiv        divisor carried by the write
//     i_sync        phase-align pulse
//     o_pending     a written divisor is waiting to be applied
//     o_clk         divided clock
//     o_tick        1-cycle pulse on each o_clk rise
// ----------------------------------------------------------------------------
module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int CNT_W   = CNT_W_DFLT,
    parameter int DEF_DIV = DEF_DIV_DFLT
) (
    input  logic             clkIn,
    input  logic             rstIn,
    input  logic             i_en,
    input  logic             i_we,
    input  logic [CNT_W-1:0] i_wdiv,
    input  logic             i_sync,
    output logic             o_pending,
    output logic             o_clk,
    output logic             o_tick
);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_div;
    logic [CNT_W-1:0] r_pdiv;
    logic             r_pending;
    logic             r_clk;
    logic             r_tick;
    ch_state_t        r_state;

    logic             w_bnd;
    logic             w_sync;

    assign w_bnd = (r_state != OFF) && (r_cnt == r_div);

`ifdef CLKDIV_SYNC_EN
    assign w_sync = i_sync && (r_state == RUN);
`else
    logic w_unused_sync;
    assign w_unused_sync = i_sync;
    assign w_sync        = 1'b0;
`endif

    always_ff @(posedge clkIn) begin
        if (rstIn) begin
            r_cnt     <= '0;
            r_div     <= CNT_W'(DEF_DIV);
            r_pdiv    <= CNT_W'(DEF_DIV);
            r_pending <= 1'b0;
            r_clk     <= 1'b0;
            r_tick    <= 1'b0;
            r_state   <= OFF;
        end else begin
            r_tick <= 1'b0;
            case (r_state)
                OFF: begin
                    r_cnt <= '0;
                    r_clk <= 1'b0;
                    if (r_pending) begin
                        r_div     <= r_pdiv;
                        r_pending <= 1'b0;
                    end
                    if (i_en) r_state <= RUN;
                end
                default: begin
                    // Sync and boundary both restart the count and are the only
                    // points where a pending divisor may take effect.
                    if (w_sync || w_bnd) begin
                        r_cnt <= '0;
                        if (r_pending) begin
                            r_div     <= r_pdiv;
                            r_pending <= 1'b0;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end

                    if (w_sync) begin
                        r_clk <= 1'b0;
                    end else if (w_bnd) begin
                        // A stopping channel finishes its current phase and parks
                        // low instead of starting a new high phase.
                        if ((r_state == STOP) && !i_en) begin
                            r_clk <= 1'b0;
                        end else begin
                            r_clk  <= ~r_clk;
                            r_tick <= ~r_clk;
                        end
                    end

                    if (i_en)
                        r_state <= RUN;
                    else if ((r_state == STOP) && w_bnd)
                        r_state <= OFF;
                    else
                        r_state <= STOP;
                end
            endcase
            // The top only grants a write while nothing is pending, so this never
            // collides with the apply paths above.
            if (i_we) begin
                r_pdiv    <= i_wdiv;
                r_pending <= 1'b1;
            end
        end
    end

    assign o_pending = r_pending;
    assign o_clk     = r_clk;
    assign o_tick    = r_tick;

endmodule

// File: rtl/prog_clk_div.sv
// ----------------------------------------------------------------------------
// prog_clk_div
//   Multi-channel programmable clock divider / tick generator. Each channel
//   produces a 50%-duty divided clock and a tick on each rise; divisors are
//   reloaded glitch-free through a valid/ready write port.
//   Optional feature macro: CLKDIV_SYNC_EN (syncIn phase-aligns running
//   channels); when undefined syncIn is ignored.
//   Ports:
//     clkIn  system clock (only clock)
//     rstIn  synchronous active-high reset
//     bus    prog_clk_div_if.slave: chEn, cfgValid/cfgCh/cfgDiv/cfgReady,
//            syncIn, clkOut, tickOut
//   This level holds the write decode, the cfgReady mux and the syncIn fan-out.
// ----------------------------------------------------------------------------
module prog_clk_div
    import clk_div_pkg::*;
#(
    parameter int NUM_CH  = 4,
    parameter int CNT_W   = CNT_W_DFLT,
    parameter int DEF_DIV = DEF_DIV_DFLT
) (
    input  logic           clkIn,
    input  logic           rstIn,
    prog_clk_div_if.slave  bus
);

    localparam int CH_W = ch_idx_w(NUM_CH);

    logic [NUM_CH-1:0] w_pending;
    logic [NUM_CH-1:0] w_we;
    logic [NUM_CH-1:0] w_clk;
    logic [NUM_CH-1:0] w_tick;
    logic              w_ready;

    // Selects that name no channel stay ready, so such writes are taken and dropped.
    always_comb begin
        w_ready = 1'b1;
        for (int i = 0; i < NUM_CH; i++) begin
            if (bus.cfgCh == CH_W'(i)) w_ready = ~w_pending[i];
        end
    end

    assign bus.cfgReady = w_ready;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        assign w_we[g] = bus.cfgValid && w_ready && (bus.cfgCh == CH_W'(g));

        clk_div_chan #(
            .CNT_W   (CNT_W),
            .DEF_DIV (DEF_DIV)
        ) u_chan (
            .clkIn     (clkIn),
            .rstIn     (rstIn),
            .i_en      (bus.chEn[g]),
            .i_we      (w_we[g]),
            .i_wdiv    (bus.cfgDiv),
            .i_sync    (bus.syncIn),
            .o_pending (w_pending[g]),
            .o_clk     (w_clk[g]),
            .o_tick    (w_tick[g])
        );
    end

    assign bus.clkOut  = w_clk;
    assign bus.tickOut = w_tick;

endmodule

// File: tb/tb_prog_clk_div.sv
// ----------------------------------------------------------------------------
// tb_prog_clk_div
//   Directed and randomized stimulus for prog_clk_div, checked every cycle
//   against a countdown-based reference model of each channel.
// ----------------------------------------------------------------------------
module tb_prog_clk_div;

    localparam int NCH  = 3;
    localparam int CW   = 8;
    localparam int DDIV = 3;
    localparam int CHW  = 2;

    localparam int M_OFF  = 0;
    localparam int M_RUN  = 1;
    localparam int M_STOP = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    prog_clk_div_if #(.NUM_CH(NCH), .CNT_W(CW)) bus ();

    prog_clk_div #(
        .NUM_CH  (NCH),
        .CNT_W   (CW),
        .DEF_DIV (DDIV)
    ) dut (
        .clkIn (clk),
        .rstIn (rst),
        .bus   (bus)
    );

    int n_chk = 0;
    int n_err = 0;

    // Reference model: each channel counts down the cycles left in its current
    // half period and flips its level when that reaches zero.
    int          m_mode [NCH];
    bit          m_lvl  [NCH];
    bit          m_tick [NCH];
    bit          m_pend [NCH];
    int unsigned m_rem  [NCH];
    int unsigned m_div  [NCH];
    int unsigned m_pdiv [NCH];

    always @(posedge clk) begin
        bit acc, en, sy;
        for (int i = 0; i < NCH; i++) begin
            acc = bus.cfgValid && (int'(bus.cfgCh) == i) && !m_pend[i];
            en  = bus.chEn[i];
`ifdef CLKDIV_SYNC_EN
            sy  = bus.syncIn && (m_mode[i] == M_RUN);
`else
            sy  = 1'b0;
`endif
            if (rst) begin
                m_mode[i] = M_OFF; m_lvl[i] = 0; m_tick[i] = 0;
                m_div[i] = DDIV;   m_pend[i] = 0; m_rem[i] = 0;
            end else begin
                m_tick[i] = 0;
                if (m_mode[i] == M_OFF) begin
                    if (m_pend[i]) begin m_div[i] = m_pdiv[i]; m_pend[i] = 0; end
                    if (en) begin m_mode[i] = M_RUN; m_rem[i] = m_div[i] + 1; end
                end else if (sy) begin
                    m_lvl[i] = 0;
                    if (m_pend[i]) begin m_div[i] = m_pdiv[i]; m_pend[i] = 0; end
                    m_rem[i]  = m_div[i] + 1;
                    m_mode[i] = en ? M_RUN : M_STOP;
                end else begin
                    m_rem[i] = m_rem[i] - 1;
                    if (m_rem[i] == 0) begin
                        if (m_pend[i]) begin m_div[i] = m_pdiv[i]; m_pend[i] = 0; end
                        m_rem[i] = m_div[i] + 1;
                        if (m_mode[i] == M_STOP && !en) begin
                            m_lvl[i]  = 0;
                            m_mode[i] = M_OFF;
                        end else begin
                            m_lvl[i]  = !m_lvl[i];
                            m_tick[i] = m_lvl[i];
                            m_mode[i] = en ? M_RUN : M_STOP;
                        end
                    end else begin
                        m_mode[i] = en ? M_RUN : M_STOP;
                    end
                end
                if (acc) begin m_pdiv[i] = bus.cfgDiv; m_pend[i] = 1; end
            end
        end
    end

    function automatic logic [NCH-1:0] e_clk();
        logic [NCH-1:0] v;
        for (int i = 0; i < NCH; i++) v[i] = m_lvl[i];
        return v;
    endfunction

    function automatic logic [NCH-1:0] e_tick();
        logic [NCH-1:0] v;
        for (int i = 0; i < NCH; i++) v[i] = m_tick[i];
        return v;
    endfunction

    function automatic logic e_rdy();
        if (int'(bus.cfgCh) < NCH) return !m_pend[int'(bus.cfgCh)];
        return 1'b1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and compare all outputs with the model mid-cycle.
    task automatic cyc();
        @(negedge clk);
        chk("clkOut",   32'(bus.clkOut),   32'(e_clk()));
        chk("tickOut",  32'(bus.tickOut),  32'(e_tick()));
        chk("cfgReady", 32'(bus.cfgReady), 32'(e_rdy()));
    endtask

    task automatic wait_tick(input int ch, output int t);
        t = 0;
        do begin cyc(); t++; end while (!bus.tickOut[ch] && t < 100);
        chk("wait_tick", 32'(bus.tickOut[ch]), 32'd1);
    endtask

    task automatic wr(input int ch, input int dv);
        logic r;
        int   k;
        bus.cfgCh = CHW'(ch); bus.cfgDiv = CW'(dv); bus.cfgValid = 1'b1;
        k = 0;
        do begin #1 r = bus.cfgReady; cyc(); k++; end while (!r && k < 60);
        bus.cfgValid = 1'b0;
        chk("wr_accept", 32'(r), 32'd1);
    endtask

    initial begin
        int t, h, nt, g0, g1;
        logic r;
        bus.chEn = '0; bus.cfgValid = 1'b0; bus.cfgCh = '0;
        bus.cfgDiv = '0; bus.syncIn = 1'b0;
        rst = 1'b1;
        cyc(); cyc();
        chk("rst_clk",  32'(bus.clkOut),   32'd0);
        chk("rst_tick", 32'(bus.tickOut),  32'd0);
        chk("rst_rdy",  32'(bus.cfgReady), 32'd1);
        rst = 1'b0;

        // 1) DEF_DIV=3: first rise 4 cycles after enable, period 8.
        bus.chEn = 3'b001;
        cyc();
        wait_tick(0, t);
        chk("t1_first_rise", 32'(t), 32'd4);
        wait_tick(0, t);
        chk("t1_period", 32'(t), 32'd8);

        // 2) Reload to div=1 mid-phase; stays pending until the boundary.
        cyc();
        wr(0, 1);
        chk("t2_rdy_pending", 32'(bus.cfgReady), 32'd0);
        wait_tick(0, t);
        wait_tick(0, t);
        chk("t2_new_period", 32'(t), 32'd4);

        // 3) Held second write to ch0, ch1 write accepted meanwhile, discard.
        wr(0, 3);
        bus.cfgCh = 2'd0; bus.cfgDiv = 8'd2; bus.cfgValid = 1'b1;
        #1 chk("t3_stall", 32'(bus.cfgReady), 32'd0);
        bus.cfgCh = 2'd1; bus.cfgDiv = 8'd5;
        #1 chk("t3_ch1_ready", 32'(bus.cfgReady), 32'd1);
        cyc();
        bus.cfgCh = 2'd0; bus.cfgDiv = 8'd2;
        h = 0;
        do begin #1 r = bus.cfgReady; cyc(); h++; end while (!r && h < 60);
        bus.cfgValid = 1'b0;
        chk("t3_held_accept", 32'(r), 32'd1);
        bus.cfgCh = 2'd3; bus.cfgDiv = 8'd7; bus.cfgValid = 1'b1;
        #1 chk("t3_discard_rdy", 32'(bus.cfgReady), 32'd1);
        cyc();
        bus.cfgValid = 1'b0;
        repeat (8) cyc();

        // 4) div=4: dropping chEn during high keeps the full 5-cycle high phase.
        wr(0, 4);
        wait_tick(0, t); wait_tick(0, t);
        wait_tick(0, t);
        bus.chEn[0] = 1'b0;
        h = 1;
        do begin cyc(); if (bus.clkOut[0]) h++; end while (bus.clkOut[0] && h < 50);
        chk("t4_high_len", 32'(h), 32'd5);
        nt = 0;
        repeat (20) begin cyc(); nt += int'(bus.tickOut[0]); end
        chk("t4_no_ticks", 32'(nt), 32'd0);
        bus.chEn[0] = 1'b1;
        wait_tick(0, t);
        bus.chEn[0] = 1'b0;
        cyc(); cyc();
        bus.chEn[0] = 1'b1;
        wait_tick(0, t);
        chk("t4_restart_gap", 32'(t), 32'd8);

        // 5) div=0 toggles every cycle; reset mid-run restores DEF_DIV.
        wr(2, 0);
        bus.chEn = 3'b101;
        cyc(); cyc();
        nt = 0;
        repeat (10) begin cyc(); nt += int'(bus.tickOut[2]); end
        chk("t5_div0_ticks", 32'(nt), 32'd5);
        rst = 1'b1;
        cyc();
        chk("t5_rst_clk",  32'(bus.clkOut),  32'd0);
        chk("t5_rst_tick", 32'(bus.tickOut), 32'd0);
        rst = 1'b0;
        bus.chEn = 3'b000;
        cyc();
        bus.chEn = 3'b001;
        cyc();
        wait_tick(0, t);
        chk("t5_def_div", 32'(t), 32'd4);

`ifdef CLKDIV_SYNC_EN
        // 6) Sync aligns ch0 (div=2) and ch1 (div=5).
        bus.chEn = 3'b011;
        wr(0, 2); wr(1, 5);
        repeat (23) cyc();
        bus.syncIn = 1'b1;
        cyc();
        bus.syncIn = 1'b0;
        chk("t6_sync_low", 32'(bus.clkOut[1:0]), 32'd0);
        t = 0; g0 = -1; g1 = -1;
        do begin
            cyc(); t++;
            if (bus.tickOut[0] && g0 < 0) g0 = t;
            if (bus.tickOut[1] && g1 < 0) g1 = t;
        end while ((g0 < 0 || g1 < 0) && t < 50);
        chk("t6_ch0_rise", 32'(g0), 32'd3);
        chk("t6_ch1_rise", 32'(g1), 32'd6);
`endif

        // Randomized traffic against the model.
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 7) == 0) bus.chEn = 3'($urandom_range(0, 7));
            bus.cfgValid = ($urandom_range(0, 3) == 0);
            bus.cfgCh    = CHW'($urandom_range(0, 3));
            bus.cfgDiv   = CW'($urandom_range(0, 6));
            bus.syncIn   = ($urandom_range(0, 19) == 0);
            rst          = ($urandom_range(0, 199) == 0);
            cyc();
        end
        rst = 1'b0; bus.cfgValid = 1'b0; bus.syncIn = 1'b0;
        cyc();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
